instr_encoder: RTL and testbench
================================

# instr_encoder

- Packs field-level instruction requests (opcode, Rx, Ry, immediate) into 16-bit instruction words.
- Writes each packed word into instruction memory at consecutive even addresses.
- Sits between the program-load/debug path and the instruction memory write port.
- Produces the exact encodings the CPU's control decoder consumes; illegal opcodes and out-of-range immediates are rejected with an error code.

## Interface
Parameters:
- ADDR_W, 16, memory address width (byte addressed).
- BASE_ADDR, 16'h0000, first write address; must be even.
- MAX_WORDS, 256, maximum words per load session.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset; the only reset.
- start  in  1  begin a session from IDLE, DONE or ERR. Ignored while busy.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_opcode  in  5  instruction opcode.
- in_rx  in  3  register field Rx.
- in_ry  in  3  register field Ry.
- in_imm  in  16  immediate, two's complement.
- in_last  in  1  final word of the session.
- mem_wr  out  1  write request to instruction memory.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  instruction word.
- busy  out  1  state is RUN or WRITE.
- done  out  1  one-cycle pulse after the last write completes.
- error  out  1  sticky error flag.
- err_code  out  2  01 illegal opcode, 10 immediate out of range, 11 overflow.
- word_count  out  $clog2(MAX_WORDS)+1  words written this session.

## Operation
Legal opcodes:
- 00000 mv, 00001 add, 00010 sub, 00011 cmp, 00100 ld, 00101 st.
- 10000 mvi, 10001 addi, 10010 subi, 10011 cmpi, 10110 mvhi.
- 01000 jr, 01001 jzr, 01010 jnr, 01100 callr.
- 11000 j, 11001 jz, 11010 jn, 11100 call.
- Any other opcode → error, err_code 01.

Encoding, with op always in [4:0]:
- 00xxx: [15:11]=0, [10:8]=Ry, [7:5]=Rx. in_imm is ignored.
- 01xxx: [15:8]=0, [7:5]=Rx. in_ry and in_imm are ignored.
- 10xxx: [15:8]=imm[7:0], [7:5]=Rx.
  - mvi/addi/subi/cmpi require in_imm[15:7] all equal (range -128..127).
  - mvhi requires in_imm[15:8]=0.
- 11xxx: [15:5]=imm[10:0]. Requires in_imm[15:10] all equal (range -1024..1023).
- A range violation → err_code 10.

States: IDLE, RUN, WRITE, DONE, ERR.
- IDLE: in_ready=0. start → RUN; addr=BASE_ADDR, word_count=0, error cleared.
- RUN: in_ready=1. On accept:
  - If word_count==MAX_WORDS → ERR with code 11 (takes priority over the other checks).
  - Else if illegal or out of range → ERR.
  - Else register the word → WRITE.
- WRITE: mem_wr=1, in_ready=0. mem_addr and mem_wdata are held stable until mem_ready. On mem_ready: addr+=2, word_count+=1; if the registered last flag is set → DONE, else → RUN.
- DONE: done=1 for exactly one cycle → IDLE. start during DONE → RUN; done still pulses.
- ERR: error=1, in_ready=0, mem_wr=0; held until start (→ RUN, cleared) or reset.
- Address wraps modulo 2^ADDR_W; no error on wrap.
- start asserted in RUN or WRITE: ignored.
- Reset mid-WRITE: the pending write is dropped and mem_wr deasserts the next cycle.

## Timing
- Reset values: in_ready=0, mem_wr=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, err_code=00, word_count=0; state IDLE.
- start sampled in cycle N → in_ready=1 in N+1.
- Accept in cycle N (in_valid & in_ready):
  - Good word: mem_wr=1 with registered data in N+1.
  - Bad word: error=1 in N+1, no mem_wr.
- mem_ready high in the first WRITE cycle → in_ready=1 again the next cycle. Peak throughput is one word per 2 cycles.
- done pulses the cycle after the final mem_wr & mem_ready.
- word_count updates in the same cycle as mem_addr.
- All outputs are registered.

## Test plan
- Reset: hold reset_n=0 with start=1 and in_valid=1 → all outputs at reset values; no mem_wr.
- BASE_ADDR=16'h0040; start; add rx=3 ry=5, then mvi rx=2 imm=16'hFFFF with last → writes 16'h0561 @0040, then 16'hFF50 @0042; done pulses once; word_count=2.
- j imm=16'hFFFE → 16'hFFD8; jz imm=1023 → 16'h7FF9; mvhi rx=7 imm=16'h00AB → 16'hABF6; jr rx=4 → 16'h0088.
- Opcode 00110 → error=1, err_code=01, no mem_wr. Then start; addi imm=200 → err_code=10. Then start; j imm=1024 → err_code=10.
- Hold mem_ready=0 for 3 cycles during WRITE → mem_wr, mem_addr and mem_wdata stable, in_ready=0, word_count unchanged; mem_ready=1 → completes and word_count increments.
- MAX_WORDS=2: third accept → err_code=11, no write. Separately, reset_n=0 during WRITE → mem_wr=0 next cycle, word_count=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs field-level instruction requests (opcode, Rx, Ry, immediate) into
//   16-bit instruction words and writes them to instruction memory at
//   consecutive even byte addresses, starting at BASE_ADDR. Illegal opcodes,
//   out-of-range immediates and session overflow stop the session with a
//   sticky error code.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   start                 begin a session (from IDLE, DONE or ERR)
//   in_valid/in_ready     request handshake
//   in_opcode/rx/ry/imm   instruction fields, in_last marks final word
//   mem_wr/mem_ready      memory write handshake
//   mem_addr/mem_wdata    write address / packed instruction word
//   busy, done, error     status (done is a one-cycle pulse, error is sticky)
//   err_code              01 illegal opcode, 10 immediate range, 11 overflow
//   word_count            words written this session
//
// State   | Meaning
// --------+----------------------------------------------------------
// IDLE    | no session; waiting for start
// RUN     | ready to accept a request
// WRITE   | packed word presented to memory, waiting for mem_ready
// DONE    | one-cycle done pulse after final write
// ERR     | request rejected; err_code valid until start or reset

module instr_encoder #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                MAX_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4:0]                     in_opcode,
  input  logic [2:0]                     in_rx,
  input  logic [2:0]                     in_ry,
  input  logic [15:0]                    in_imm,
  input  logic                           in_last,
  output logic                           mem_wr,
  input  logic                           mem_ready,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [15:0]                    mem_wdata,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     err_code,
  output logic [$clog2(MAX_WORDS):0]     word_count
);

  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state, state_next;

  logic        last_q;
  logic [15:0] enc_word;
  logic        legal;
  logic        in_range;
  logic        accept;
  logic        full;
  logic        session_start;
  logic        in_ready_d, mem_wr_d, busy_d, done_d, error_d;

  assign accept        = in_valid && (state == S_RUN);
  assign full          = (word_count == MAX_CNT);
  assign session_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  // Opcode decode, range check and packing. Opcode always lands in [4:0].
  always_comb begin
    enc_word = '0;
    legal    = 1'b0;
    in_range = 1'b1;
    case (in_opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101: begin
        legal    = 1'b1;
        enc_word = {5'b0, in_ry, in_rx, in_opcode};
      end
      5'b01000, 5'b01001, 5'b01010, 5'b01100: begin
        legal    = 1'b1;
        enc_word = {8'b0, in_rx, in_opcode};
      end
      5'b10000, 5'b10001, 5'b10010, 5'b10011: begin
        // signed 8-bit immediate: sign bit and everything above must agree
        legal    = 1'b1;
        in_range = (&in_imm[15:7]) || !(|in_imm[15:7]);
        enc_word = {in_imm[7:0], in_rx, in_opcode};
      end
      5'b10110: begin
        // mvhi loads the high byte, so the immediate is an unsigned byte
        legal    = 1'b1;
        in_range = !(|in_imm[15:8]);
        enc_word = {in_imm[7:0], in_rx, in_opcode};
      end
      5'b11000, 5'b11001, 5'b11010, 5'b11100: begin
        legal    = 1'b1;
        in_range = (&in_imm[15:10]) || !(|in_imm[15:10]);
        enc_word = {in_imm[10:0], in_opcode};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      word_count <= '0;
      err_code   <= 2'b00;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= in_ready_d;
      mem_wr   <= mem_wr_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;

      if (session_start) begin
        mem_addr   <= BASE_ADDR;
        word_count <= '0;
        err_code   <= 2'b00;
      end

      if (accept) begin
        // overflow is checked first so a full session reports 11 regardless
        if (full) begin
          err_code <= ERR_OVERFLOW;
        end else if (!legal) begin
          err_code <= ERR_OPCODE;
        end else if (!in_range) begin
          err_code <= ERR_RANGE;
        end else begin
          mem_wdata <= enc_word;
          last_q    <= in_last;
        end
      end

      if ((state == S_WRITE) && mem_ready) begin
        mem_addr   <= mem_addr + ADDR_W'(2);
        word_count <= word_count + CW'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          if (full || !legal || !in_range) state_next = S_ERR;
          else                             state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) state_next = last_q ? S_DONE : S_RUN;
      end
      S_DONE: begin
        state_next = start ? S_RUN : S_IDLE;
      end
      S_ERR: begin
        if (start) state_next = S_RUN;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so every
  // status output is glitch-free and aligned with the state it describes.
  always_comb begin
    in_ready_d = 1'b0;
    mem_wr_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_next)
      S_RUN: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        mem_wr_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      S_ERR: begin
        error_d = 1'b1;
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed test of instr_encoder with BASE_ADDR=16'h0040 and MAX_WORDS=2.
//   Expected instruction words are hand-packed constants.

`timescale 1ns/1ps

module tb_instr_encoder;

  localparam int                ADDR_W    = 16;
  localparam logic [15:0]       BASE      = 16'h0040;
  localparam int                MAXW      = 2;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [4:0]  in_opcode = '0;
  logic [2:0]  in_rx     = '0;
  logic [2:0]  in_ry     = '0;
  logic [15:0] in_imm    = '0;
  logic        in_last   = 1'b0;
  logic        mem_ready = 1'b0;

  logic              in_ready;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [$clog2(MAXW):0] word_count;

  int n_checks = 0;
  int n_errors = 0;

  instr_encoder #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rx     (in_rx),
    .in_ry     (in_ry),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [15:0] imm, input logic last);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rx     = rx;
    in_ry     = ry;
    in_imm    = imm;
    in_last   = last;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic sess_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " start rdy"},   in_ready,   1);
    chk({tag, " start busy"},  busy,       1);
    chk({tag, " start wc"},    word_count, 0);
    chk({tag, " start addr"},  mem_addr,   BASE);
    chk({tag, " start error"}, error,      0);
  endtask

  task automatic good(input string tag, input logic [4:0] op, input logic [2:0] rx,
                      input logic [2:0] ry, input logic [15:0] imm, input logic last,
                      input logic [15:0] exp_addr, input logic [15:0] exp_data);
    chk({tag, " rdy"}, in_ready, 1);
    drive(op, rx, ry, imm, last);
    chk({tag, " wr"},    mem_wr,    1);
    chk({tag, " data"},  mem_wdata, exp_data);
    chk({tag, " addr"},  mem_addr,  exp_addr);
    chk({tag, " nrdy"},  in_ready,  0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic bad(input string tag, input logic [4:0] op, input logic [2:0] rx,
                     input logic [15:0] imm, input logic [1:0] code);
    chk({tag, " rdy"}, in_ready, 1);
    drive(op, rx, 3'd0, imm, 1'b0);
    chk({tag, " error"}, error,    1);
    chk({tag, " code"},  err_code, code);
    chk({tag, " nowr"},  mem_wr,   0);
    chk({tag, " nrdy"},  in_ready, 0);
    chk({tag, " nbusy"}, busy,     0);
  endtask

  initial begin
    // Reset held with start and in_valid asserted
    reset_n   = 1'b0;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_opcode = 5'b00001;
    repeat (3) tick();
    chk("rst in_ready", in_ready,   0);
    chk("rst mem_wr",   mem_wr,     0);
    chk("rst addr",     mem_addr,   BASE);
    chk("rst wdata",    mem_wdata,  0);
    chk("rst busy",     busy,       0);
    chk("rst done",     done,       0);
    chk("rst error",    error,      0);
    chk("rst code",     err_code,   0);
    chk("rst wc",       word_count, 0);
    start    = 1'b0;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    chk("idle rdy", in_ready, 0);

    // Two-word session
    sess_start("s1");
    good("add", 5'b00001, 3'd3, 3'd5, 16'h0000, 1'b0, 16'h0040, 16'h0561);
    chk("add wc",   word_count, 1);
    chk("add rdy2", in_ready,   1);
    chk("add addr2", mem_addr,  16'h0042);
    chk("add nodone", done,     0);
    good("mvi", 5'b10000, 3'd2, 3'd0, 16'hFFFF, 1'b1, 16'h0042, 16'hFF50);
    chk("s1 done",  done,       1);
    chk("s1 wc",    word_count, 2);
    chk("s1 addr",  mem_addr,   16'h0044);
    tick();
    chk("s1 done off", done,     0);
    chk("s1 idle busy", busy,    0);
    chk("s1 idle rdy", in_ready, 0);

    // Encodings; second session starts from DONE
    sess_start("j");
    good("j", 5'b11000, 3'd0, 3'd0, 16'hFFFE, 1'b1, 16'h0040, 16'hFFD8);
    chk("j done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart done off", done,       0);
    chk("restart rdy",      in_ready,   1);
    chk("restart wc",       word_count, 0);
    chk("restart addr",     mem_addr,   BASE);
    good("jz", 5'b11001, 3'd0, 3'd0, 16'd1023, 1'b1, 16'h0040, 16'h7FF9);
    tick();
    sess_start("mvhi");
    good("mvhi", 5'b10110, 3'd7, 3'd0, 16'h00AB, 1'b1, 16'h0040, 16'hABF6);
    tick();
    sess_start("jr");
    good("jr", 5'b01000, 3'd4, 3'd6, 16'h1234, 1'b1, 16'h0040, 16'h0088);
    tick();
    sess_start("cmpi");
    good("cmpi", 5'b10011, 3'd1, 3'd0, 16'hFF80, 1'b1, 16'h0040, 16'h8033);
    tick();

    // Rejections
    sess_start("ill");
    bad("ill", 5'b00110, 3'd1, 16'h0000, 2'b01);
    tick();
    chk("err hold", error,    1);
    chk("err hold code", err_code, 1);
    sess_start("addi");
    bad("addi200", 5'b10001, 3'd1, 16'd200, 2'b10);
    sess_start("j1024");
    bad("j1024", 5'b11000, 3'd0, 16'd1024, 2'b10);
    sess_start("mvhi256");
    bad("mvhi256", 5'b10110, 3'd2, 16'h0100, 2'b10);
    sess_start("clr");
    chk("clr code", err_code, 0);

    // Memory stall, start during WRITE ignored
    chk("stall rdy", in_ready, 1);
    drive(5'b00100, 3'd1, 3'd2, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      chk("stall wr",   mem_wr,     1);
      chk("stall addr", mem_addr,   16'h0040);
      chk("stall data", mem_wdata,  16'h0224);
      chk("stall nrdy", in_ready,   0);
      chk("stall wc",   word_count, 0);
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("stall done", done,       1);
    chk("stall wc1",  word_count, 1);
    tick();

    // Overflow at MAX_WORDS; takes priority over illegal opcode
    sess_start("ov");
    good("ov1", 5'b00000, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0040, 16'h0220);
    good("ov2", 5'b00010, 3'd3, 3'd4, 16'h0000, 1'b0, 16'h0042, 16'h0462);
    chk("ov wc", word_count, 2);
    bad("ov3", 5'b00110, 3'd1, 16'h0000, 2'b11);

    // Reset during WRITE
    sess_start("rw");
    good("rw1", 5'b00000, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0040, 16'h0220);
    chk("rw rdy", in_ready, 1);
    drive(5'b00001, 3'd3, 3'd5, 16'h0000, 1'b0);
    chk("rw wr", mem_wr, 1);
    reset_n = 1'b0;
    tick();
    chk("rw wr off", mem_wr,     0);
    chk("rw wc",     word_count, 0);
    chk("rw addr",   mem_addr,   BASE);
    reset_n = 1'b1;
    tick();
    chk("rw idle rdy", in_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
